// File: rtl/fetch_queue_pkg.sv
// Shared types and constants for the instruction fetch queue.
package fetch_queue_pkg;

    // Fetch request FSM: at most one memory request is ever in flight.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } fq_state_t;

    // One queue entry: the fetched word and the address of the next sequential instruction.
    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc4;
    } fq_entry_t;

    localparam int          ENTRY_W = $bits(fq_entry_t);
    localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/fetch_queue_ram.sv
// Entry storage for the fetch queue: DEPTH x 64-bit, one write port,
// one asynchronous read port.
module fq_ram
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [ENTRY_W-1:0]       wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [ENTRY_W-1:0]       rdata
);

    logic [ENTRY_W-1:0] mem [DEPTH];

    // Write the enqueued entry at the tail slot.
    // NOTE: the array has no reset; the queue's occupancy count decides which slots are meaningful.
    always_ff @(posedge clk) begin
        if (we) begin
            // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
            mem[waddr] <= wdata;
        end
    end

    // Head entry is visible without a clock edge.
    assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue: issues sequential word fetches (one outstanding),
// buffers returned words with their pc+4, and offers them to the IF/ID register.
// A redirect flushes the queue and restarts fetching at redirect_pc; a response
// already in flight at that moment is discarded in the DRAIN state.
// Optional feature macro: FETCH_QUEUE_BYPASS_EN -- a response arriving while the
// queue is empty is presented on deq_* in the same cycle.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        deq_valid,
    input  logic        deq_ready,
    output logic [31:0] deq_inst,
    output logic [31:0] deq_pc4
);

    localparam int            AW  = $clog2(DEPTH);
    localparam logic [AW:0]   CAP = (AW+1)'(DEPTH);

    fq_state_t   state;
    logic [31:0] fetch_pc;
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [AW:0]   count;
    logic        seen_enq;

    logic        rsp_take;
    logic        bypass;
    logic        enq;
    logic        pop;
    logic        deq_fire;
    logic        req_fire;
    fq_entry_t   rd_entry;
    fq_entry_t   wr_entry;
    logic [ENTRY_W-1:0] rd_bits;

    // While in WAIT, fetch_pc already holds request address + 4, so it doubles as the entry's pc4.
    assign wr_entry  = '{inst: imem_rsp_data, pc4: fetch_pc};
    assign rd_entry  = fq_entry_t'(rd_bits);
    assign imem_addr = fetch_pc;

    // Handshake decode and output selection.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        deq_inst = 32'h0;
        deq_pc4  = 32'h0;

        // Reset is folded in so the request drops the instant rst goes low.
        imem_req_valid = rst && (state == IDLE) && (count < CAP) && !redirect;
        req_fire       = imem_req_valid && imem_req_ready;

        rsp_take = (state == WAIT) && imem_rsp_valid && !redirect;
`ifdef FETCH_QUEUE_BYPASS_EN
        bypass   = rsp_take && (count == '0);
`else
        bypass   = 1'b0;
`endif
        deq_valid = ((count != '0) || bypass) && !redirect;
        deq_fire  = deq_valid && deq_ready;

        // A bypassed word consumed immediately never touches the storage.
        enq = rsp_take && !(bypass && deq_ready);
        pop = deq_fire && !bypass;

        if (bypass) begin
            deq_inst = imem_rsp_data;
            deq_pc4  = fetch_pc;
        end else if (seen_enq) begin
            deq_inst = rd_entry.inst;
            deq_pc4  = rd_entry.pc4;
        end
    end

    // Request FSM: IDLE issues, WAIT holds for the response, DRAIN swallows a stale response.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (req_fire) state <= WAIT;
                WAIT:    if (imem_rsp_valid) state <= IDLE;
                         else if (redirect) state <= DRAIN;
                DRAIN:   if (imem_rsp_valid) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Fetch address, queue pointers and occupancy; redirect overrides enqueue and dequeue.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc <= RESET_PC;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            seen_enq <= 1'b0;
        end else if (redirect) begin
            fetch_pc <= redirect_pc;
            head     <= tail;
            count    <= '0;
        end else begin
            if (req_fire) fetch_pc <= fetch_pc + PC_STEP;
            if (enq) begin
                tail     <= tail + 1'b1;
                seen_enq <= 1'b1;
            end
            if (pop) head <= head + 1'b1;
            count <= count + {{AW{1'b0}}, enq} - {{AW{1'b0}}, pop};
        end
    end

    fq_ram #(
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (enq),
        .waddr (tail),
        .wdata (wr_entry),
        .raddr (head),
        .rdata (rd_bits)
    );

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: a vector table for the reset/start-up
// sequence, hand-written multi-cycle sequences, and randomized traffic against a
// queue-based reference model. Expectations follow FETCH_QUEUE_BYPASS_EN if defined.
module tb_fetch_queue;

    localparam int DEPTH = 4;
`ifdef FETCH_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        deq_valid;
    logic        deq_ready;
    logic [31:0] deq_inst;
    logic [31:0] deq_pc4;

    int n_cmp = 0;
    int n_bad = 0;

    fetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .deq_valid      (deq_valid),
        .deq_ready      (deq_ready),
        .deq_inst       (deq_inst),
        .deq_pc4        (deq_pc4)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    function automatic logic [31:0] inst_of(input logic [31:0] addr);
        return addr ^ 32'hC0DE_0000;
    endfunction

    task automatic clear_inputs();
        redirect       = 1'b0;
        redirect_pc    = 32'h0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        deq_ready      = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        clear_inputs();
        settle();
        check("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        check("rst_deq_valid", {31'b0, deq_valid}, 32'd0);
        step();
        step();
        rst = 1'b1;
    endtask

    // Wait (bounded) for a request, check its address, accept it and answer next cycle.
    task automatic fetch_one(input logic [31:0] exp_addr);
        imem_req_ready = 1'b1;
        settle();
        for (int i = 0; i < 20 && !imem_req_valid; i++) step();
        check("fetch_req_valid", {31'b0, imem_req_valid}, 32'd1);
        check("fetch_req_addr", imem_addr, exp_addr);
        step();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = inst_of(exp_addr);
        step();
        imem_rsp_valid = 1'b0;
    endtask

    typedef struct {
        logic        ready;
        logic        rsp_v;
        logic [31:0] rsp_d;
        logic        dq;
        logic        e_rv;
        logic [31:0] e_addr;
        logic        e_dv;
        logic        chk;
        logic [31:0] e_inst;
        logic [31:0] e_pc4;
    } vec_t;

    localparam int NV = 9;
    vec_t vecs[NV];

    // Reference model state for the random phase.
    logic [63:0] mq[$];
    logic [31:0] m_pc;
    logic [31:0] m_addr;
    int          m_out;       // 0 none, 1 live request, 2 stale (to be discarded)
    bit          mem_pending;
    int          mem_wait;

    initial begin
        rst = 1'b0;
        clear_inputs();

        // ---------------- start-up vector table ----------------
        //            ready rsp_v rsp_d            dq   e_rv e_addr  e_dv  chk   e_inst                    e_pc4
        vecs[0] = '{1'b1, 1'b0, 32'h0,           1'b0, 1'b1, 32'h0, 1'b0, 1'b1, 32'h0,                     32'h0};
        vecs[1] = '{1'b0, 1'b1, 32'hA000_0000,   1'b0, 1'b0, 32'h0, BYP,  1'b1, BYP ? 32'hA000_0000 : 32'h0, BYP ? 32'h4 : 32'h0};
        vecs[2] = '{1'b1, 1'b0, 32'h0,           1'b0, 1'b1, 32'h4, 1'b1, 1'b1, 32'hA000_0000,             32'h4};
        vecs[3] = '{1'b0, 1'b1, 32'hA000_0001,   1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'hA000_0000,             32'h4};
        vecs[4] = '{1'b0, 1'b0, 32'h0,           1'b0, 1'b1, 32'h8, 1'b1, 1'b1, 32'hA000_0001,             32'h8};
        vecs[5] = '{1'b1, 1'b0, 32'h0,           1'b1, 1'b1, 32'h8, 1'b1, 1'b1, 32'hA000_0001,             32'h8};
        vecs[6] = '{1'b0, 1'b0, 32'h0,           1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0,                     32'h0};
        vecs[7] = '{1'b0, 1'b1, 32'hA000_0002,   1'b0, 1'b0, 32'h0, BYP,  BYP,  32'hA000_0002,             32'hC};
        vecs[8] = '{1'b0, 1'b0, 32'h0,           1'b0, 1'b1, 32'hC, 1'b1, 1'b1, 32'hA000_0002,             32'hC};

        do_reset();
        for (int i = 0; i < NV; i++) begin
            imem_req_ready = vecs[i].ready;
            imem_rsp_valid = vecs[i].rsp_v;
            imem_rsp_data  = vecs[i].rsp_d;
            deq_ready      = vecs[i].dq;
            settle();
            check($sformatf("vec%0d_req_valid", i), {31'b0, imem_req_valid}, {31'b0, vecs[i].e_rv});
            if (vecs[i].e_rv) check($sformatf("vec%0d_addr", i), imem_addr, vecs[i].e_addr);
            check($sformatf("vec%0d_deq_valid", i), {31'b0, deq_valid}, {31'b0, vecs[i].e_dv});
            if (vecs[i].chk) begin
                check($sformatf("vec%0d_deq_inst", i), deq_inst, vecs[i].e_inst);
                check($sformatf("vec%0d_deq_pc4", i), deq_pc4, vecs[i].e_pc4);
            end
            step();
        end
        clear_inputs();

        // ---------------- full queue back-pressure ----------------
        do_reset();
        for (int i = 0; i < DEPTH; i++) fetch_one(32'(i * 4));
        imem_req_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            check("full_no_req", {31'b0, imem_req_valid}, 32'd0);
            step();
        end
        deq_ready = 1'b1;
        settle();
        check("full_deq_valid", {31'b0, deq_valid}, 32'd1);
        check("full_deq_inst", deq_inst, inst_of(32'h0));
        check("full_deq_pc4", deq_pc4, 32'h4);
        step();
        deq_ready = 1'b0;
        fetch_one(32'h10);
        imem_req_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            check("refull_no_req", {31'b0, imem_req_valid}, 32'd0);
            step();
        end
        clear_inputs();

        // ---------------- redirect in WAIT, late response dropped ----------------
        do_reset();
        imem_req_ready = 1'b1;
        settle();
        check("rdw_req_addr", imem_addr, 32'h0);
        step();
        imem_req_ready = 1'b0;
        redirect       = 1'b1;
        redirect_pc    = 32'h100;
        settle();
        check("rdw_req_off", {31'b0, imem_req_valid}, 32'd0);
        step();
        redirect = 1'b0;
        settle();
        check("rdw_drain_no_req", {31'b0, imem_req_valid}, 32'd0);
        step();
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD_BEEF;
        settle();
        check("rdw_late_no_req", {31'b0, imem_req_valid}, 32'd0);
        check("rdw_late_no_deq", {31'b0, deq_valid}, 32'd0);
        step();
        imem_rsp_valid = 1'b0;
        settle();
        check("rdw_dropped", {31'b0, deq_valid}, 32'd0);
        check("rdw_new_req", {31'b0, imem_req_valid}, 32'd1);
        check("rdw_new_addr", imem_addr, 32'h100);
        fetch_one(32'h100);
        settle();
        check("rdw_deq_valid", {31'b0, deq_valid}, 32'd1);
        check("rdw_deq_pc4", deq_pc4, 32'h104);
        check("rdw_deq_inst", deq_inst, inst_of(32'h100));
        clear_inputs();

        // ---------------- redirect with simultaneous response and deq ----------------
        do_reset();
        fetch_one(32'h0);
        imem_req_ready = 1'b1;
        settle();
        check("rsim_req_addr", imem_addr, 32'h4);
        step();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h1234_5678;
        redirect       = 1'b1;
        redirect_pc    = 32'h200;
        deq_ready      = 1'b1;
        settle();
        check("rsim_deq_off", {31'b0, deq_valid}, 32'd0);
        check("rsim_req_off", {31'b0, imem_req_valid}, 32'd0);
        step();
        clear_inputs();
        settle();
        check("rsim_empty", {31'b0, deq_valid}, 32'd0);
        check("rsim_idle_req", {31'b0, imem_req_valid}, 32'd1);
        check("rsim_req_addr2", imem_addr, 32'h200);

        // ---------------- response latency / bypass ----------------
        do_reset();
        imem_req_ready = 1'b1;
        settle();
        step();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h2002_0005;
        deq_ready      = 1'b1;
        settle();
`ifdef FETCH_QUEUE_BYPASS_EN
        check("byp_deq_valid", {31'b0, deq_valid}, 32'd1);
        check("byp_deq_inst", deq_inst, 32'h2002_0005);
        check("byp_deq_pc4", deq_pc4, 32'h4);
`else
        check("lat_same_cycle", {31'b0, deq_valid}, 32'd0);
`endif
        step();
        imem_rsp_valid = 1'b0;
        deq_ready      = 1'b0;
        settle();
`ifdef FETCH_QUEUE_BYPASS_EN
        check("byp_not_enqueued", {31'b0, deq_valid}, 32'd0);
`else
        check("lat_next_cycle", {31'b0, deq_valid}, 32'd1);
        check("lat_deq_inst", deq_inst, 32'h2002_0005);
`endif
        clear_inputs();

        // ---------------- reset during WAIT ----------------
        do_reset();
        fetch_one(32'h0);
        imem_req_ready = 1'b1;
        settle();
        step();
        imem_req_ready = 1'b0;
        settle();
        check("mrst_pre_deq", {31'b0, deq_valid}, 32'd1);
        rst = 1'b0;
        settle();
        check("mrst_req_off", {31'b0, imem_req_valid}, 32'd0);
        check("mrst_deq_off", {31'b0, deq_valid}, 32'd0);
        step();
        step();
        rst = 1'b1;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hBAD0_BAD0;
        settle();
        check("mrst_first_req", {31'b0, imem_req_valid}, 32'd1);
        check("mrst_first_addr", imem_addr, 32'h0);
        check("mrst_rsp_deq", {31'b0, deq_valid}, 32'd0);
        step();
        imem_rsp_valid = 1'b0;
        settle();
        check("mrst_rsp_ignored", {31'b0, deq_valid}, 32'd0);
        check("mrst_still_idle", {31'b0, imem_req_valid}, 32'd1);
        clear_inputs();

        // ---------------- randomized traffic vs reference model ----------------
        do_reset();
        mq.delete();
        m_pc        = 32'h0;
        m_addr      = 32'h0;
        m_out       = 0;
        mem_pending = 1'b0;
        mem_wait    = 0;
        begin
            int dq_pct = 50;
            for (int cyc = 0; cyc < 3000; cyc++) begin
                logic        rsp_v;
                logic [31:0] rsp_d;
                logic        rdr;
                logic [31:0] rpc;
                logic        rdy;
                logic        dq;
                logic        byp;
                logic        e_rv;
                logic        e_dv;
                logic [63:0] head;

                if (cyc % 250 == 0) dq_pct = $urandom_range(0, 3) * 33;
                rsp_v = 1'b0;
                rsp_d = $urandom;
                if (mem_pending) begin
                    if (mem_wait == 0) begin
                        rsp_v       = 1'b1;
                        mem_pending = 1'b0;
                    end else begin
                        mem_wait--;
                    end
                end else if ($urandom_range(0, 15) == 0) begin
                    rsp_v = 1'b1;   // stray response while nothing is outstanding
                end
                rdr = ($urandom_range(0, 15) == 0);
                rpc = $urandom & 32'hFFFF_FFFC;
                rdy = ($urandom_range(0, 3) != 0);
                dq  = ($urandom_range(0, 99) < dq_pct);

                redirect       = rdr;
                redirect_pc    = rpc;
                imem_req_ready = rdy;
                imem_rsp_valid = rsp_v;
                imem_rsp_data  = rsp_d;
                deq_ready      = dq;
                settle();

                byp  = BYP && (m_out == 1) && rsp_v && (mq.size() == 0) && !rdr;
                e_rv = (m_out == 0) && (mq.size() < DEPTH) && !rdr;
                e_dv = ((mq.size() > 0) || byp) && !rdr;
                head = byp ? {rsp_d, m_addr + 32'd4} : ((mq.size() > 0) ? mq[0] : 64'h0);

                check("rnd_req_valid", {31'b0, imem_req_valid}, {31'b0, e_rv});
                if (e_rv) check("rnd_req_addr", imem_addr, m_pc);
                check("rnd_deq_valid", {31'b0, deq_valid}, {31'b0, e_dv});
                if (e_dv) begin
                    check("rnd_deq_inst", deq_inst, head[63:32]);
                    check("rnd_deq_pc4", deq_pc4, head[31:0]);
                end

                if (rdr) begin
                    mq.delete();
                    m_pc  = rpc;
                    m_out = (m_out != 0 && !rsp_v) ? 2 : 0;
                end else begin
                    if (e_dv && dq && !byp) void'(mq.pop_front());
                    if (rsp_v && m_out == 1) begin
                        if (!(byp && dq)) mq.push_back({rsp_d, m_addr + 32'd4});
                        m_out = 0;
                    end else if (rsp_v && m_out == 2) begin
                        m_out = 0;
                    end
                    if (e_rv && rdy) begin
                        m_out       = 1;
                        m_addr      = m_pc;
                        m_pc        = m_pc + 32'd4;
                        mem_pending = 1'b1;
                        mem_wait    = $urandom_range(0, 2);
                    end
                end
                step();
            end
        end
        clear_inputs();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
